// File: rtl/mm_pkg.sv
// mm_pkg: shared types and width helpers for the matrix-multiply datapath
package mm_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int GUARD_DEF = 8;
  function automatic int accw(input int bitwidth, input int guard);
    return 2 * bitwidth + guard;
  endfunction
  function automatic int lenw(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/dot_accumulator_if.sv
// dot_accumulator_if: command, product-stream and result handshake bundle
interface dot_accumulator_if #(
  parameter int BITWIDTH = 32,
  parameter int GUARD = mm_pkg::GUARD_DEF,
  parameter int MAX_LEN = 256
);
  import mm_pkg::*;
  localparam int ACCW = accw(BITWIDTH, GUARD);
  localparam int LENW = lenw(MAX_LEN);
  logic start;
  logic [LENW-1:0] len;
  logic [2*BITWIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic [ACCW-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic busy;
  logic ovf;
  modport master (
    output start, len, din, din_valid, dout_ready,
    input din_ready, dout, dout_valid, busy, ovf
  );
  modport slave (
    input start, len, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, busy, ovf
  );
endinterface

// File: rtl/dot_accumulator_acc_sat_add.sv
// acc_sat_add: ACCW-bit unsigned add with carry-out; clamps to all-ones when DOT_ACC_SATURATE_EN is defined
module acc_sat_add #(
  parameter int ACCW = 72,
  parameter int DW = 64
) (
  input  logic [ACCW-1:0] acc,
  input  logic [DW-1:0]   din,
  output logic [ACCW-1:0] sum,
  output logic            carry
);
  logic [ACCW:0] din_x;
  logic [ACCW:0] full;
  assign din_x = {{(ACCW + 1 - DW){1'b0}}, din};
  assign full = {1'b0, acc} + din_x;
  assign carry = full[ACCW];
`ifdef DOT_ACC_SATURATE_EN
  assign sum = carry ? '1 : full[ACCW-1:0];
`else
  assign sum = full[ACCW-1:0];
`endif
endmodule

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums len unsigned products into one dot-product result with valid/ready on both sides
// Saturating accumulation is selected by DOT_ACC_SATURATE_EN (see acc_sat_add).
module dot_accumulator
  import mm_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int GUARD = GUARD_DEF,
  parameter int MAX_LEN = 256
) (
  input logic clk,
  input logic rst,
  dot_accumulator_if.slave bus
);
  localparam int ACCW = accw(BITWIDTH, GUARD);
  localparam int LENW = lenw(MAX_LEN);
  state_t state, state_n;
  logic [ACCW-1:0] acc, sum;
  logic [LENW-1:0] cnt, cnt_n, len_q, len_c;
  logic carry, ovf, beat, start_ok;
  acc_sat_add #(.ACCW(ACCW), .DW(2 * BITWIDTH)) u_add (
    .acc(acc),
    .din(bus.din),
    .sum(sum),
    .carry(carry)
  );
  assign len_c = (bus.len > LENW'(MAX_LEN)) ? LENW'(MAX_LEN) : bus.len;
  assign start_ok = (state == IDLE) && bus.start;
  assign beat = (state == ACCUM) && bus.din_valid;
  assign cnt_n = cnt + 1'b1;
  assign bus.din_ready = (state == ACCUM);
  assign bus.dout_valid = (state == DONE);
  assign bus.busy = (state != IDLE);
  assign bus.dout = acc;
  assign bus.ovf = ovf;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.start ? ((len_c == '0) ? DONE : ACCUM) : IDLE;
      ACCUM:   state_n = (beat && cnt_n == len_q) ? DONE : ACCUM;
      DONE:    state_n = bus.dout_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      len_q <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        acc <= '0;
        cnt <= '0;
        len_q <= len_c;
        ovf <= 1'b0;
      end else if (beat) begin
        acc <= sum;
        cnt <= cnt_n;
        ovf <= ovf | carry;
      end
    end
  end
endmodule
